// File: rtl/ddr3_app_arbiter.sv
// Two-requester round-robin front end for the MIG user interface.
// One command in flight at a time; read responses are routed back to
// their requester through an in-order tag FIFO.
module ddr3_app_arbiter #(
   parameter int unsigned RD_TAG_DEPTH = 16
) (
   input  logic           ui_clk,
   input  logic           ui_clk_sync_rst,
   input  logic           init_calib_complete,
   input  logic [1:0]     req_valid,
   output logic [1:0]     req_ready,
   input  logic [1:0]     req_write,
   input  logic [55:0]    req_addr,
   input  logic [1023:0]  req_wdata,
   input  logic [127:0]   req_wmask,
   output logic [1:0]     rsp_valid,
   output logic [511:0]   rsp_data,
   output logic [27:0]    app_addr,
   output logic [2:0]     app_cmd,
   output logic           app_en,
   output logic [511:0]   app_wdf_data,
   output logic [63:0]    app_wdf_mask,
   output logic           app_wdf_wren,
   output logic           app_wdf_end,
   input  logic           app_rdy,
   input  logic           app_wdf_rdy,
   input  logic           app_rd_data_valid,
   input  logic [511:0]   app_rd_data,
   output logic [6:0]     rd_outstanding,
   output logic           tag_underflow
);

   localparam int unsigned PTR_W = (RD_TAG_DEPTH > 1) ? $clog2(RD_TAG_DEPTH) : 1;
   localparam int unsigned CNT_W = 7;
   localparam logic [2:0]  CMD_WR = 3'b000;
   localparam logic [2:0]  CMD_RD = 3'b001;

   typedef enum logic {IDLE, ISSUE} state_t;

   state_t             state;
   logic               last_grant;
   logic               tag_mem [RD_TAG_DEPTH];
   logic [PTR_W-1:0]   wr_ptr;
   logic [PTR_W-1:0]   rd_ptr;

   logic               tag_full;
   logic [1:0]         elig;
   logic [1:0]         grant;
   logic               grant_id;
   logic               push;
   logic               pop;
   logic               cmd_ok;
   logic               dat_ok;
   logic [27:0]        sel_addr;
   logic [511:0]       sel_wdata;
   logic [63:0]        sel_wmask;

   // Eligibility, round-robin grant, FIFO push/pop and handshake completion
   always_comb begin
      tag_full = (rd_outstanding == CNT_W'(RD_TAG_DEPTH));
      elig     = 2'b00;
      for (int i = 0; i < 2; i++) begin
         elig[i] = (state == IDLE) && !ui_clk_sync_rst && init_calib_complete &&
                   req_valid[i] && (req_write[i] || !tag_full);
      end
      grant = elig;
      if (elig == 2'b11) begin
         grant = last_grant ? 2'b01 : 2'b10;
      end
      grant_id = grant[1];
      push     = (grant != 2'b00) && !req_write[grant_id];
      pop      = app_rd_data_valid && (rd_outstanding != '0);
      cmd_ok   = !app_en || app_rdy;
      dat_ok   = !app_wdf_wren || app_wdf_rdy;
   end

   assign req_ready = grant;
   assign sel_addr  = grant_id ? req_addr[55:28]     : req_addr[27:0];
   assign sel_wdata = grant_id ? req_wdata[1023:512] : req_wdata[511:0];
   assign sel_wmask = grant_id ? req_wmask[127:64]   : req_wmask[63:0];

   // Command FSM: latch the granted request, then hold it on the MIG until both handshakes finish
   always_ff @(posedge ui_clk or posedge ui_clk_sync_rst) begin
      if (ui_clk_sync_rst) begin
         state        <= IDLE;
         last_grant   <= 1'b1;
         app_addr     <= '0;
         app_cmd      <= '0;
         app_en       <= 1'b0;
         app_wdf_data <= '0;
         app_wdf_mask <= '0;
         app_wdf_wren <= 1'b0;
         app_wdf_end  <= 1'b0;
      end else begin
         case (state)
            IDLE: begin
               if (grant != 2'b00) begin
                  app_addr     <= sel_addr;
                  app_cmd      <= req_write[grant_id] ? CMD_WR : CMD_RD;
                  app_wdf_data <= sel_wdata;
                  app_wdf_mask <= sel_wmask;
                  app_en       <= 1'b1;
                  app_wdf_wren <= req_write[grant_id];
                  app_wdf_end  <= req_write[grant_id];
                  last_grant   <= grant_id;
                  state        <= ISSUE;
               end
            end
            ISSUE: begin
               if (app_rdy) begin
                  app_en <= 1'b0;
               end
               if (app_wdf_rdy) begin
                  app_wdf_wren <= 1'b0;
                  app_wdf_end  <= 1'b0;
               end
               if (cmd_ok && dat_ok) begin
                  state <= IDLE;
               end
            end
            default: state <= IDLE;
         endcase
      end
   end

   // Tag storage; contents are don't-care while the pointers say empty
   always_ff @(posedge ui_clk) begin
      if (push) begin
         tag_mem[wr_ptr] <= grant_id;
      end
   end

   // Tag FIFO pointers and occupancy
   always_ff @(posedge ui_clk or posedge ui_clk_sync_rst) begin
      if (ui_clk_sync_rst) begin
         wr_ptr         <= '0;
         rd_ptr         <= '0;
         rd_outstanding <= '0;
      end else begin
         if (push) begin
            wr_ptr <= wr_ptr + PTR_W'(1);
         end
         if (pop) begin
            rd_ptr <= rd_ptr + PTR_W'(1);
         end
         case ({push, pop})
            2'b10:   rd_outstanding <= rd_outstanding + CNT_W'(1);
            2'b01:   rd_outstanding <= rd_outstanding - CNT_W'(1);
            default: rd_outstanding <= rd_outstanding;
         endcase
      end
   end

   // Read response routing and sticky underflow detection
   always_ff @(posedge ui_clk or posedge ui_clk_sync_rst) begin
      if (ui_clk_sync_rst) begin
         rsp_valid     <= 2'b00;
         rsp_data      <= '0;
         tag_underflow <= 1'b0;
      end else begin
         rsp_valid <= 2'b00;
         if (pop) begin
            rsp_valid <= tag_mem[rd_ptr] ? 2'b10 : 2'b01;
            rsp_data  <= app_rd_data;
         end
         if (app_rd_data_valid && (rd_outstanding == '0)) begin
            tag_underflow <= 1'b1;
         end
      end
   end

endmodule

// File: tb/tb_ddr3_app_arbiter.sv
// Self-checking bench for ddr3_app_arbiter: directed scenarios plus a
// randomized phase, checked against a transaction-level reference model.
module tb_ddr3_app_arbiter;

   localparam int unsigned DEPTH = 16;

   logic           ui_clk = 1'b0;
   logic           ui_clk_sync_rst;
   logic           init_calib_complete;
   logic [1:0]     req_valid;
   logic [1:0]     req_ready;
   logic [1:0]     req_write;
   logic [55:0]    req_addr;
   logic [1023:0]  req_wdata;
   logic [127:0]   req_wmask;
   logic [1:0]     rsp_valid;
   logic [511:0]   rsp_data;
   logic [27:0]    app_addr;
   logic [2:0]     app_cmd;
   logic           app_en;
   logic [511:0]   app_wdf_data;
   logic [63:0]    app_wdf_mask;
   logic           app_wdf_wren;
   logic           app_wdf_end;
   logic           app_rdy;
   logic           app_wdf_rdy;
   logic           app_rd_data_valid;
   logic [511:0]   app_rd_data;
   logic [6:0]     rd_outstanding;
   logic           tag_underflow;

   ddr3_app_arbiter #(.RD_TAG_DEPTH(DEPTH)) dut (
      .ui_clk              (ui_clk),
      .ui_clk_sync_rst     (ui_clk_sync_rst),
      .init_calib_complete (init_calib_complete),
      .req_valid           (req_valid),
      .req_ready           (req_ready),
      .req_write           (req_write),
      .req_addr            (req_addr),
      .req_wdata           (req_wdata),
      .req_wmask           (req_wmask),
      .rsp_valid           (rsp_valid),
      .rsp_data            (rsp_data),
      .app_addr            (app_addr),
      .app_cmd             (app_cmd),
      .app_en              (app_en),
      .app_wdf_data        (app_wdf_data),
      .app_wdf_mask        (app_wdf_mask),
      .app_wdf_wren        (app_wdf_wren),
      .app_wdf_end         (app_wdf_end),
      .app_rdy             (app_rdy),
      .app_wdf_rdy         (app_wdf_rdy),
      .app_rd_data_valid   (app_rd_data_valid),
      .app_rd_data         (app_rd_data),
      .rd_outstanding      (rd_outstanding),
      .tag_underflow       (tag_underflow)
   );

   always #5 ui_clk = ~ui_clk;

   int checks   = 0;
   int failures = 0;

   // reference model: one command in flight, queue of read owners in command order
   bit            mdl_busy, mdl_cmd_done, mdl_dat_done, mdl_wr, mdl_last, mdl_uf;
   logic [27:0]   mdl_addr;
   logic [511:0]  mdl_wdata;
   logic [63:0]   mdl_mask;
   bit            tagq[$];
   logic [1:0]    exp_rsp_v;
   logic [511:0]  exp_rsp_d;
   int            mig_pending;

   // stimulus knobs and observation logs
   int            p_req[2];
   int            p_wr, p_rdy, p_wdf, p_ret;
   bit            fixed_addr, force_rdv;
   logic [1:0]    granted_flag;
   logic [1:0]    ogq[$];
   logic [27:0]   oaq[$];
   int            en_cnt, wren_cnt;

   task automatic chk(input string tag, input logic [511:0] obs, input logic [511:0] exp);
      checks++;
      assert (obs === exp) else begin
         failures++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   function automatic logic [511:0] rnd512();
      logic [511:0] v;
      for (int k = 0; k < 16; k++) v[k*32 +: 32] = $urandom;
      return v;
   endfunction

   task automatic new_req(input int i);
      req_write[i]         = (int'($urandom_range(99)) < p_wr);
      req_addr[i*28 +: 28] = fixed_addr ? 28'(16 * (i + 1)) : 28'($urandom);
      req_wdata[i*512 +: 512] = rnd512();
      req_wmask[i*64 +: 64]   = {$urandom, $urandom};
      req_valid[i]         = 1'b1;
   endtask

   task automatic model_reset();
      mdl_busy = 0; mdl_cmd_done = 0; mdl_dat_done = 0; mdl_wr = 0;
      mdl_last = 1; mdl_uf = 0;
      tagq.delete();
      exp_rsp_v = 2'b00; exp_rsp_d = '0;
      mig_pending = 0;
      granted_flag = 2'b00;
   endtask

   task automatic do_reset();
      ui_clk_sync_rst   = 1'b1;
      app_rd_data_valid = 1'b0;
      force_rdv         = 1'b0;
      #2;
      chk("rst_req_ready", 512'(req_ready), 512'(0));
      chk("rst_app_en", 512'(app_en), 512'(0));
      chk("rst_app_addr", 512'(app_addr), 512'(0));
      chk("rst_app_cmd", 512'(app_cmd), 512'(0));
      chk("rst_wdf_data", app_wdf_data, 512'(0));
      chk("rst_wdf_mask", 512'(app_wdf_mask), 512'(0));
      chk("rst_wdf_wren_end", 512'({app_wdf_wren, app_wdf_end}), 512'(0));
      chk("rst_rsp_valid", 512'(rsp_valid), 512'(0));
      chk("rst_rsp_data", rsp_data, 512'(0));
      chk("rst_rd_outstanding", 512'(rd_outstanding), 512'(0));
      chk("rst_tag_underflow", 512'(tag_underflow), 512'(0));
      model_reset();
      repeat (2) @(posedge ui_clk);
      #1 ui_clk_sync_rst = 1'b0;
   endtask

   // compare DUT against the model for the current cycle, then advance the model
   task automatic monitor();
      logic [1:0] elig, exp_g;
      bit         id;
      chk("rd_outstanding", 512'(rd_outstanding), 512'(tagq.size()));
      chk("tag_underflow", 512'(tag_underflow), 512'(mdl_uf));
      chk("rsp_valid", 512'(rsp_valid), 512'(exp_rsp_v));
      if (exp_rsp_v != 2'b00) chk("rsp_data", rsp_data, exp_rsp_d);
      chk("app_en", 512'(app_en), 512'(mdl_busy && !mdl_cmd_done));
      chk("app_wdf_wren", 512'(app_wdf_wren), 512'(mdl_busy && mdl_wr && !mdl_dat_done));
      chk("app_wdf_end", 512'(app_wdf_end), 512'(mdl_busy && mdl_wr && !mdl_dat_done));
      if (mdl_busy) begin
         chk("app_addr", 512'(app_addr), 512'(mdl_addr));
         chk("app_cmd", 512'(app_cmd), 512'(mdl_wr ? 3'b000 : 3'b001));
         if (mdl_wr) begin
            chk("app_wdf_data", app_wdf_data, mdl_wdata);
            chk("app_wdf_mask", 512'(app_wdf_mask), 512'(mdl_mask));
         end
      end
      for (int i = 0; i < 2; i++)
         elig[i] = !mdl_busy && init_calib_complete && req_valid[i] &&
                   (req_write[i] || (tagq.size() < DEPTH));
      exp_g = (elig == 2'b11) ? (mdl_last ? 2'b01 : 2'b10) : elig;
      chk("req_ready", 512'(req_ready), 512'(exp_g));
      if (req_ready != 2'b00) ogq.push_back(req_ready);
      if (app_en && app_rdy) oaq.push_back(app_addr);
      en_cnt   += int'(app_en);
      wren_cnt += int'(app_wdf_wren);

      if (mdl_busy) begin
         if (!mdl_cmd_done && app_rdy) begin
            mdl_cmd_done = 1;
            if (!mdl_wr) mig_pending++;
         end
         if (mdl_wr && !mdl_dat_done && app_wdf_rdy) mdl_dat_done = 1;
         if (mdl_cmd_done && (mdl_dat_done || !mdl_wr)) mdl_busy = 0;
      end
      exp_rsp_v = 2'b00;
      if (app_rd_data_valid) begin
         if (tagq.size() == 0) mdl_uf = 1;
         else begin
            id        = tagq.pop_front();
            exp_rsp_v = id ? 2'b10 : 2'b01;
            exp_rsp_d = app_rd_data;
         end
      end
      granted_flag = exp_g;
      if (exp_g != 2'b00) begin
         id           = exp_g[1];
         mdl_busy     = 1; mdl_cmd_done = 0; mdl_dat_done = 0;
         mdl_wr       = req_write[id];
         mdl_addr     = id ? req_addr[55:28] : req_addr[27:0];
         mdl_wdata    = id ? req_wdata[1023:512] : req_wdata[511:0];
         mdl_mask     = id ? req_wmask[127:64] : req_wmask[63:0];
         mdl_last     = id;
         if (!mdl_wr) tagq.push_back(id);
      end
   endtask

   // requesters and MIG behaviour for the next cycle
   task automatic drive();
      for (int i = 0; i < 2; i++) begin
         if (granted_flag[i]) req_valid[i] = 1'b0;
         else if (!req_valid[i] && (int'($urandom_range(99)) < p_req[i])) new_req(i);
      end
      granted_flag = 2'b00;
      app_rdy      = (int'($urandom_range(99)) < p_rdy);
      app_wdf_rdy  = (int'($urandom_range(99)) < p_wdf);
      app_rd_data_valid = 1'b0;
      if (force_rdv) begin
         force_rdv = 1'b0;
         app_rd_data_valid = 1'b1;
         app_rd_data = rnd512();
         if (mig_pending > 0) mig_pending--;
      end else if ((mig_pending > 0) && (int'($urandom_range(99)) < p_ret)) begin
         app_rd_data_valid = 1'b1;
         app_rd_data = rnd512();
         mig_pending--;
      end
   endtask

   task automatic cycle();
      @(negedge ui_clk);
      monitor();
      @(posedge ui_clk);
      #1 drive();
   endtask

   initial begin
      ui_clk_sync_rst = 1'b1; init_calib_complete = 1'b0;
      req_valid = '0; req_write = '0; req_addr = '0; req_wdata = '0; req_wmask = '0;
      app_rdy = 1'b0; app_wdf_rdy = 1'b0; app_rd_data_valid = 1'b0; app_rd_data = '0;
      p_req[0] = 0; p_req[1] = 0; p_wr = 0; p_rdy = 100; p_wdf = 100; p_ret = 100;
      fixed_addr = 1'b0; force_rdv = 1'b0; en_cnt = 0; wren_cnt = 0;
      model_reset();
      do_reset();

      // both requesters reading 0x10 / 0x20: grants alternate starting with 0
      init_calib_complete = 1'b1;
      fixed_addr = 1'b1; p_req[0] = 100; p_req[1] = 100;
      ogq.delete(); oaq.delete();
      repeat (12) cycle();
      chk("rr_grant_count", 512'(ogq.size() >= 4), 512'(1));
      if (ogq.size() >= 4) begin
         chk("rr_grant0", 512'(ogq[0]), 512'(2'b01));
         chk("rr_grant1", 512'(ogq[1]), 512'(2'b10));
         chk("rr_grant2", 512'(ogq[2]), 512'(2'b01));
         chk("rr_grant3", 512'(ogq[3]), 512'(2'b10));
      end
      if (oaq.size() >= 2) begin
         chk("rr_addr0", 512'(oaq[0]), 512'(28'h10));
         chk("rr_addr1", 512'(oaq[1]), 512'(28'h20));
      end
      p_req[0] = 0; p_req[1] = 0; fixed_addr = 1'b0;
      repeat (20) cycle();

      // write whose data handshake lags the command handshake
      p_rdy = 100; p_wdf = 0; p_wr = 100;
      new_req(0);
      p_wr = 0; en_cnt = 0; wren_cnt = 0; ogq.delete();
      repeat (4) cycle();
      p_wdf = 100;
      repeat (6) cycle();
      chk("wr_app_en_cycles", 512'(en_cnt), 512'(1));
      chk("wr_wren_cycles", 512'(wren_cnt), 512'(5));
      chk("wr_single_grant", 512'(ogq.size()), 512'(1));

      // fill the tag FIFO: reads stall, a write still goes, one return frees a slot
      p_ret = 0; p_req[0] = 100;
      repeat (45) cycle();
      chk("full_outstanding", 512'(rd_outstanding), 512'(16));
      p_wr = 100; new_req(1); p_wr = 0;
      ogq.delete();
      repeat (6) cycle();
      chk("full_write_only", 512'(ogq.size() == 1 ? ogq[0] : 2'b00), 512'(2'b10));
      force_rdv = 1'b1;
      ogq.delete();
      repeat (4) cycle();
      chk("full_pop_read_grant", 512'(ogq.size() > 0 ? ogq[0] : 2'b00), 512'(2'b01));
      p_req[0] = 0; p_ret = 100;
      repeat (60) cycle();

      // read data with nothing outstanding is flagged and sticks
      do_reset();
      force_rdv = 1'b1;
      repeat (3) cycle();
      chk("underflow_set", 512'(tag_underflow), 512'(1));
      repeat (5) cycle();
      chk("underflow_sticky", 512'(tag_underflow), 512'(1));
      do_reset();
      chk("underflow_cleared", 512'(tag_underflow), 512'(0));

      // no calibration: nothing is granted or issued
      init_calib_complete = 1'b0;
      new_req(0); new_req(1);
      ogq.delete(); en_cnt = 0;
      repeat (20) cycle();
      chk("nocal_no_grant", 512'(ogq.size()), 512'(0));
      chk("nocal_no_app_en", 512'(en_cnt), 512'(0));
      init_calib_complete = 1'b1;
      repeat (10) cycle();

      // randomized traffic, including a reset in the middle of activity
      for (int c = 0; c < 15; c++) begin
         p_req[0] = int'($urandom_range(100)); p_req[1] = int'($urandom_range(100));
         p_wr  = int'($urandom_range(100));
         p_rdy = int'($urandom_range(100, 20)); p_wdf = int'($urandom_range(100, 20));
         p_ret = (c % 4 == 1) ? 0 : int'($urandom_range(100));
         for (int k = 0; k < 200; k++) begin
            if ($urandom_range(99) == 0) init_calib_complete = ~init_calib_complete;
            if ((c == 7) && (k == 100)) do_reset();
            cycle();
         end
      end

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule

// File: doc/ddr3_app_arbiter.md
DDR3_APP_ARBITER -- requirements
Module: ddr3_app_arbiter

Interface
REQ-001 SHALL have parameter RD_TAG_DEPTH, default 16: maximum outstanding reads, power of two, 2..64.
REQ-002 SHALL have port ui_clk, input, 1: sole clock, the MIG user-interface clock.
REQ-003 SHALL have port ui_clk_sync_rst, input, 1: asynchronous, active-high reset.
REQ-004 SHALL have port init_calib_complete, input, 1: MIG calibration done.
REQ-005 SHALL have port req_valid, input, 2: per-requester command valid; requester i is bit i.
REQ-006 SHALL have port req_ready, output, 2: per-requester accept pulse.
REQ-007 SHALL have port req_write, input, 2: 1 = write, 0 = read.
REQ-008 SHALL have port req_addr, input, 56: requester i address at [28i+27:28i].
REQ-009 SHALL have port req_wdata, input, 1024: requester i data at [512i+511:512i].
REQ-010 SHALL have port req_wmask, input, 128: requester i byte mask at [64i+63:64i].
REQ-011 SHALL have port rsp_valid, output, 2: read data valid for requester i.
REQ-012 SHALL have port rsp_data, output, 512: read data, shared by both requesters.
REQ-013 SHALL have ports app_addr (output, 28), app_cmd (output, 3), app_en (output, 1), app_wdf_data (output, 512), app_wdf_mask (output, 64), app_wdf_wren (output, 1) and app_wdf_end (output, 1), which drive the MIG.
REQ-014 SHALL have ports app_rdy, app_wdf_rdy, app_rd_data_valid (input, 1 each) and app_rd_data (input, 512), which come from the MIG.
REQ-015 SHALL have port rd_outstanding, output, 7: current tag FIFO occupancy.
REQ-016 SHALL have port tag_underflow, output, 1: sticky error flag.

Function
REQ-017 SHALL implement FSM states IDLE and ISSUE.
REQ-018 In IDLE, a requester SHALL be eligible when req_valid[i]=1, init_calib_complete=1, and either req_write[i]=1 or the tag FIFO is not full.
REQ-019 Arbitration SHALL be round-robin: if both are eligible, grant the requester not granted last; after reset, requester 0 wins the first tie.
REQ-020 On grant, req_ready[i] SHALL be 1 for exactly that IDLE cycle.
REQ-021 On grant, the block SHALL latch addr, the command (write=3'b000, read=3'b001), wdata and wmask, and go to ISSUE on the next cycle.
REQ-022 On a read grant, the requester id SHALL be pushed into the tag FIFO in the grant cycle.
REQ-023 In ISSUE, app_en SHALL be held at 1 until the first cycle with app_rdy=1, inclusive.
REQ-024 In ISSUE for a write, app_wdf_wren=app_wdf_end=1 SHALL be held until the first cycle with app_wdf_rdy=1, inclusive; the two handshakes are independent and may complete in either order or in the same cycle.
REQ-025 For a read, app_wdf_wren SHALL stay 0 and the data handshake counts as already done.
REQ-026 The FSM SHALL return to IDLE on the cycle after both handshakes are done; peak throughput is 1 request per 2 cycles.
REQ-027 app_addr, app_cmd, app_wdf_data and app_wdf_mask SHALL hold stable throughout ISSUE.
REQ-028 On app_rd_data_valid=1, the block SHALL pop the tag FIFO head h and, on the next cycle, drive rsp_valid[h]=1 with rsp_data = the captured app_rd_data (latency 1).
REQ-029 Responses SHALL be returned in command order; there is no response backpressure.
REQ-030 A push and a pop in the same cycle SHALL leave the occupancy unchanged; pointers wrap modulo RD_TAG_DEPTH.
REQ-031 A FIFO-full condition SHALL block only read grants; writes still proceed.
REQ-032 app_rd_data_valid=1 while the FIFO is empty SHALL set tag_underflow=1 (sticky until reset), with no pop and rsp_valid=0.
REQ-033 init_calib_complete falling SHALL block new grants only; an ISSUE in progress completes.

Reset
REQ-034 Reset SHALL asynchronously force state=IDLE, all outputs to 0, FIFO empty, the round-robin pointer to favour requester 0, and tag_underflow=0.
REQ-035 Reset mid-ISSUE SHALL abandon the command; queued tags are discarded.

Verification
REQ-036 Both requesters hold valid reads at 0x10 and 0x20 after calibration, app_rdy=1 -> grants alternate 0,1,0,... and app_addr shows 0x10 then 0x20.
REQ-037 Write with app_wdf_rdy delayed 3 cycles relative to app_rdy -> app_en is high 1 cycle, wdf_wren is high until the data handshake, then IDLE; the next grant comes no earlier than the following cycle.
REQ-038 Issue 16 reads with no read data returned -> rd_outstanding=16 and further reads are stalled while a write is still granted; one app_rd_data_valid -> occupancy 15 and a read is granted.
REQ-039 Reads from requesters 1,0,1 with data D0,D1,D2 -> rsp_valid pattern 2'b10, 2'b01, 2'b10, each 1 cycle after the corresponding app_rd_data_valid.
REQ-040 app_rd_data_valid pulse with an empty FIFO -> tag_underflow=1 and stays 1; reset clears it.
REQ-041 init_calib_complete=0 with req_valid=2'b11 -> req_ready=0 and app_en=0 indefinitely.
